// File: rtl/div_seq_if.sv
// Operand/result handshake bundle for div_seq: operands in on in_valid/in_ready,
// results out on out_valid/out_ready.
interface div_seq_if #(
  parameter int N = 8,
  parameter int M = N
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [M-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] q;
  logic [M-1:0] r;
  logic         dbz;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, q, r, dbz
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, q, r, dbz
  );
endinterface

// File: rtl/div_seq.sv
// Bit-serial restoring divider, one quotient bit per clock; out_valid N edges after accept.
// Accepts only in IDLE; result held in DONE until out_ready, and retained afterwards.
module div_seq #(
  parameter int N = 8,
  parameter int M = N
) (
  input  logic      clk,
  input  logic      rst,
  div_seq_if.slave  bus
);
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [N-1:0]  dvd;
  logic [M-1:0]  dvs;
  logic [M:0]    p;
  logic [N-1:0]  qacc;
  logic          zdiv;

  logic [M:0]    t;
  logic [M:0]    t_sub;
  logic [M:0]    p_nxt;
  logic          qbit;

  // One restoring step: the dividend MSB shifts into the partial remainder.
  always_comb begin
    t     = {p[M-1:0], dvd[N-1]};
    t_sub = t - {1'b0, dvs};
    qbit  = (t >= {1'b0, dvs});
    p_nxt = qbit ? t_sub : t;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      dvd           <= '0;
      dvs           <= '0;
      p             <= '0;
      qacc          <= '0;
      zdiv          <= 1'b0;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.q         <= '0;
      bus.r         <= '0;
      bus.dbz       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid && bus.in_ready) begin
            state        <= RUN;
            dvd          <= bus.a;
            dvs          <= bus.b;
            p            <= '0;
            qacc         <= '0;
            cnt          <= CW'(N - 1);
            zdiv         <= (bus.b == '0);
            bus.in_ready <= 1'b0;
          end
        end
        RUN: begin
          dvd  <= {dvd[N-2:0], 1'b0};
          p    <= p_nxt;
          qacc <= {qacc[N-2:0], qbit};
          cnt  <= cnt - 1'b1;
          // Published outputs only change on the final step so they hold during RUN.
          if (cnt == '0) begin
            state         <= DONE;
            bus.out_valid <= 1'b1;
            bus.q         <= {qacc[N-2:0], qbit};
            bus.r         <= p_nxt[M-1:0];
            bus.dbz       <= zdiv;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state         <= IDLE;
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
          end
        end
        default: begin
          state         <= IDLE;
          bus.out_valid <= 1'b0;
          bus.in_ready  <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_div_seq.sv
// Bench for div_seq: directed N=M=8 vectors plus random streams on N=8/M=4 and N=16/M=8,
// all checked every cycle against a transaction-level model.
module tb_div_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  div_seq_if #(.N(8),  .M(8)) i0 ();
  div_seq_if #(.N(8),  .M(4)) i1 ();
  div_seq_if #(.N(16), .M(8)) i2 ();

  div_seq #(.N(8),  .M(8)) d0 (.clk(clk), .rst(rst), .bus(i0));
  div_seq #(.N(8),  .M(4)) d1 (.clk(clk), .rst(rst), .bus(i1));
  div_seq #(.N(16), .M(8)) d2 (.clk(clk), .rst(rst), .bus(i2));

  int total = 0;
  int bad   = 0;
  logic chk_en = 1'b0;
  logic sweep_go = 1'b0;
  logic sw1_done = 1'b0;
  logic sw2_done = 1'b0;

  // Transaction model: 0 idle, 1 computing, 2 result presented.
  int          nw [3] = '{8, 8, 16};
  int          mw [3] = '{8, 4, 8};
  int          mst  [3];
  int          mrem [3];
  logic [15:0] m_q [3], m_r [3], pend_q [3], pend_r [3];
  logic        m_dbz [3], pend_dbz [3], m_rdy [3], m_vld [3];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 20) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic mstep(input int k, input logic iv, input logic orr,
                       input logic [15:0] av, input logic [15:0] bv);
    if (rst) begin
      mst[k] = 0; mrem[k] = 0;
      m_q[k] = '0; m_r[k] = '0; m_dbz[k] = 1'b0;
      m_rdy[k] = 1'b1; m_vld[k] = 1'b0;
    end else begin
      case (mst[k])
        0: if (iv) begin
          if (bv == 0) begin
            pend_q[k]   = 16'((32'd1 << nw[k]) - 1);
            pend_r[k]   = av & 16'((32'd1 << mw[k]) - 1);
            pend_dbz[k] = 1'b1;
          end else begin
            pend_q[k]   = av / bv;
            pend_r[k]   = av % bv;
            pend_dbz[k] = 1'b0;
          end
          mst[k] = 1; mrem[k] = nw[k]; m_rdy[k] = 1'b0;
        end
        1: begin
          mrem[k]--;
          if (mrem[k] == 0) begin
            mst[k] = 2; m_vld[k] = 1'b1;
            m_q[k] = pend_q[k]; m_r[k] = pend_r[k]; m_dbz[k] = pend_dbz[k];
          end
        end
        default: if (orr) begin
          mst[k] = 0; m_vld[k] = 1'b0; m_rdy[k] = 1'b1;
        end
      endcase
    end
  endtask

  always @(posedge clk) begin
    mstep(0, i0.in_valid, i0.out_ready, 16'(i0.a), 16'(i0.b));
    mstep(1, i1.in_valid, i1.out_ready, 16'(i1.a), 16'(i1.b));
    mstep(2, i2.in_valid, i2.out_ready, 16'(i2.a), 16'(i2.b));
  end

  task automatic cmp(input int k, input logic rdy, input logic vld,
                     input logic [15:0] qv, input logic [15:0] rv, input logic dv);
    chk($sformatf("in_ready[%0d]", k),  32'(rdy), 32'(m_rdy[k]));
    chk($sformatf("out_valid[%0d]", k), 32'(vld), 32'(m_vld[k]));
    chk($sformatf("q[%0d]", k),         32'(qv),  32'(m_q[k]));
    chk($sformatf("r[%0d]", k),         32'(rv),  32'(m_r[k]));
    chk($sformatf("dbz[%0d]", k),       32'(dv),  32'(m_dbz[k]));
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp(0, i0.in_ready, i0.out_valid, 16'(i0.q), 16'(i0.r), i0.dbz);
      cmp(1, i1.in_ready, i1.out_valid, 16'(i1.q), 16'(i1.r), i1.dbz);
      cmp(2, i2.in_ready, i2.out_valid, 16'(i2.q), 16'(i2.r), i2.dbz);
    end
  end

  // Directed op on d0; hold>0 keeps out_ready low for that many cycles after out_valid.
  task automatic op0(input logic [7:0] av, input logic [7:0] bv, input logic [7:0] eq,
                     input logic [7:0] er, input logic ed, input int hold);
    int   lat;
    logic ir_hi;
    i0.out_ready = (hold == 0);
    i0.a = av; i0.b = bv; i0.in_valid = 1'b1;
    @(posedge clk); #1;
    i0.in_valid = 1'b0;
    lat = 0; ir_hi = 1'b0;
    while (!i0.out_valid && lat < 40) begin
      if (i0.in_ready) ir_hi = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    if (i0.in_ready) ir_hi = 1'b1;
    chk($sformatf("latency %0d/%0d", av, bv), lat, 8);
    chk($sformatf("in_ready_busy %0d/%0d", av, bv), 32'(ir_hi), 0);
    chk($sformatf("q %0d/%0d", av, bv), 32'(i0.q), 32'(eq));
    chk($sformatf("r %0d/%0d", av, bv), 32'(i0.r), 32'(er));
    chk($sformatf("dbz %0d/%0d", av, bv), 32'(i0.dbz), 32'(ed));
    chk($sformatf("model_q %0d/%0d", av, bv), 32'(m_q[0]), 32'(eq));
    chk($sformatf("model_r %0d/%0d", av, bv), 32'(m_r[0]), 32'(er));
    if (hold > 0) begin
      for (int h = 0; h < hold; h++) begin
        i0.in_valid = 1'b1; i0.a = 8'($urandom); i0.b = 8'($urandom);
        @(posedge clk); #1;
        chk("hold_valid", 32'(i0.out_valid), 1);
        chk("hold_ready", 32'(i0.in_ready), 0);
        chk("hold_q", 32'(i0.q), 32'(eq));
        chk("hold_r", 32'(i0.r), 32'(er));
      end
      i0.in_valid = 1'b0;
      i0.out_ready = 1'b1;
    end
    @(posedge clk); #1;
    chk("idle_in_ready", 32'(i0.in_ready), 1);
    chk("idle_out_valid", 32'(i0.out_valid), 0);
    chk("idle_q_retained", 32'(i0.q), 32'(eq));
  endtask

  initial begin
    i0.in_valid = 1'b0; i0.a = '0; i0.b = '0; i0.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 32'(i0.in_ready), 1);
    chk("rst_out_valid", 32'(i0.out_valid), 0);
    chk("rst_q", 32'(i0.q), 0);
    chk("rst_r", 32'(i0.r), 0);
    chk("rst_dbz", 32'(i0.dbz), 0);
    @(posedge clk); #1;
    sweep_go = 1'b1;

    op0(8'd200, 8'd7,   8'd28,  8'd4,   1'b0, 0);
    op0(8'd5,   8'd9,   8'd0,   8'd5,   1'b0, 0);
    op0(8'd255, 8'd1,   8'd255, 8'd0,   1'b0, 0);
    op0(8'd255, 8'd255, 8'd1,   8'd0,   1'b0, 0);
    op0(8'hA5,  8'd0,   8'hFF,  8'hA5,  1'b1, 0);
    op0(8'd10,  8'd3,   8'd3,   8'd1,   1'b0, 0);
    op0(8'd123, 8'd10,  8'd12,  8'd3,   1'b0, 5);

    // Reset with four bits still to process (counter at 3).
    i0.a = 8'd100; i0.b = 8'd3; i0.in_valid = 1'b1;
    @(posedge clk); #1;
    i0.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    i0.in_valid = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    i0.in_valid = 1'b0;
    chk("midrst_out_valid", 32'(i0.out_valid), 0);
    chk("midrst_in_ready", 32'(i0.in_ready), 1);
    chk("midrst_q", 32'(i0.q), 0);
    chk("midrst_r", 32'(i0.r), 0);
    op0(8'd100, 8'd3, 8'd33, 8'd1, 1'b0, 0);

    wait (sw1_done && sw2_done);
    @(posedge clk); #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    i1.in_valid = 1'b0; i1.a = '0; i1.b = '0; i1.out_ready = 1'b1;
    wait (sweep_go);
    for (int c = 0; c < 5000; c++) begin
      @(posedge clk); #1;
      i1.in_valid  = ($urandom_range(0, 3) != 0);
      i1.a         = ($urandom_range(0, 9) == 0) ? 8'hFF : 8'($urandom);
      i1.b         = ($urandom_range(0, 6) == 0) ? 4'd0 : 4'($urandom);
      i1.out_ready = ($urandom_range(0, 4) != 0);
    end
    @(posedge clk); #1;
    i1.in_valid = 1'b0; i1.out_ready = 1'b1;
    sw1_done = 1'b1;
  end

  initial begin
    i2.in_valid = 1'b0; i2.a = '0; i2.b = '0; i2.out_ready = 1'b1;
    wait (sweep_go);
    for (int c = 0; c < 5000; c++) begin
      @(posedge clk); #1;
      i2.in_valid  = ($urandom_range(0, 3) != 0);
      i2.a         = ($urandom_range(0, 9) == 0) ? 16'hFFFF : 16'($urandom);
      i2.b         = ($urandom_range(0, 6) == 0) ? 8'd0 :
                     ($urandom_range(0, 1) == 0) ? 8'($urandom_range(1, 15)) : 8'($urandom);
      i2.out_ready = ($urandom_range(0, 4) != 0);
    end
    @(posedge clk); #1;
    i2.in_valid = 1'b0; i2.out_ready = 1'b1;
    sw2_done = 1'b1;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish before 2000000");
    $fatal(1, "timeout");
  end
endmodule
